// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command-decoded word RAM between an SPI slave deserialiser
// and serialiser. Each valid rx word carries a 2-bit command and a payload.
// The four commands are set write pointer, write data, set read pointer and
// read data. The write and read pointers are independent. They can advance
// with wrap for burst transfers. An out-of-range pointer load is rejected and
// flagged with a one-cycle error pulse.
module spi_ram_burst #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  addr_err
);

  typedef enum logic [1:0] {
    CMD_SET_WA = 2'b00,
    CMD_WR     = 2'b01,
    CMD_SET_RA = 2'b10,
    CMD_RD     = 2'b11
  } cmd_e;

  typedef struct packed {
    cmd_e                  cmd;
    logic [DATA_WIDTH-1:0] payload;
  } req_t;

  // Last legal pointer value. Wrap happens here, not at 2^ADDR_SIZE, so
  // depths that are not a power of two never reach an unused index.
  localparam logic [ADDR_SIZE-1:0]  LAST_PTR = ADDR_SIZE'(MEM_DEPTH - 1);
  // Depth held one bit wider than the payload. This keeps the range compare
  // exact when MEM_DEPTH == 2^DATA_WIDTH.
  localparam logic [DATA_WIDTH:0]   DEPTH_X  = (DATA_WIDTH+1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  addr_err_q, addr_err_d;

  req_t                  req;
  logic                  in_range;
  logic                  mem_we;

  // Advance a pointer by one, wrapping from the last word back to zero.
  function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_SIZE'(1);
  endfunction

  // Split the rx word into command and payload, and check the payload
  // against the memory depth for the pointer-load commands.
  always_comb begin
    req      = req_t'(din);
    in_range = ({1'b0, req.payload} < DEPTH_X);
    // A write is suppressed while reset is held. Reset is asynchronous, but
    // the memory port is not reset, so it must not act on stray rx words.
    mem_we   = rst_n && rx_valid && (req.cmd == CMD_WR);
  end

  // Next-state decode for the pointers and the registered tx/err outputs.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    addr_err_d = 1'b0;
    if (rx_valid) begin
      unique case (req.cmd)
        CMD_SET_WA: begin
          if (in_range) wr_ptr_d = req.payload[ADDR_SIZE-1:0];
          else          addr_err_d = 1'b1;
        end
        CMD_WR: begin
          if (AUTO_INC) wr_ptr_d = next_ptr(wr_ptr_q);
        end
        CMD_SET_RA: begin
          if (in_range) rd_ptr_d = req.payload[ADDR_SIZE-1:0];
          else          addr_err_d = 1'b1;
        end
        CMD_RD: begin
          // A write at the previous edge has already landed in mem_q, so
          // read-after-write on consecutive cycles sees the new data.
          dout_d     = mem_q[rd_ptr_q];
          tx_valid_d = 1'b1;
          if (AUTO_INC) rd_ptr_d = next_ptr(rd_ptr_q);
        end
        default: ;
      endcase
    end
  end

  // Pointer and output registers. They clear on reset, but memory does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Memory write port. It has no reset, so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= req.payload;
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench for spi_ram_burst. Two instances are used: u0 has
// AUTO_INC=1 and u1 has AUTO_INC=0. Both use depth 8 and 8-bit data.
// Stimulus pushes the expected read data and error pulses, stamped with the
// cycle they must appear in. A monitor checks every cycle.
module tb_spi_ram_burst;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din_a  [2];
  logic       rxv_a  [2];
  logic [7:0] dout_a [2];
  logic       tx_a   [2];
  logic       err_a  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         stamp;
    logic [7:0] val;
  } exp_t;

  exp_t       rq [2][$];
  int         eq [2][$];
  logic [7:0] last_dout [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_ram_burst #(.MEM_DEPTH(8), .ADDR_SIZE(3), .DATA_WIDTH(8), .AUTO_INC(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din_a[0]), .rx_valid(rxv_a[0]),
    .dout(dout_a[0]), .tx_valid(tx_a[0]), .addr_err(err_a[0]));

  spi_ram_burst #(.MEM_DEPTH(8), .ADDR_SIZE(3), .DATA_WIDTH(8), .AUTO_INC(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din_a[1]), .rx_valid(rxv_a[1]),
    .dout(dout_a[1]), .tx_valid(tx_a[1]), .addr_err(err_a[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Drive one command word into instance d for the next edge.
  // ev is the expected read data. ee marks an expected addr_err pulse.
  task automatic send(input int d, input logic [1:0] c, input logic [7:0] p,
                      input logic [7:0] ev = 8'h00, input bit ee = 1'b0);
    @(negedge clk);
    rxv_a[0] = 1'b0;
    rxv_a[1] = 1'b0;
    din_a[d] = {c, p};
    rxv_a[d] = 1'b1;
    if (c == 2'b11) rq[d].push_back('{cyc + 1, ev});
    if (ee) eq[d].push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxv_a[0] = 1'b0;
      rxv_a[1] = 1'b0;
    end
  endtask

  // Monitor: compares every output of both instances once per cycle.
  initial begin
    last_dout[0] = 8'h00;
    last_dout[1] = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          chk($sformatf("rst_dout%0d", d), 32'(dout_a[d]), 32'h0);
          chk($sformatf("rst_tx%0d", d),   32'(tx_a[d]),   32'h0);
          chk($sformatf("rst_err%0d", d),  32'(err_a[d]),  32'h0);
          last_dout[d] = 8'h00;
        end else begin
          if (rq[d].size() > 0 && rq[d][0].stamp == cyc) begin
            chk($sformatf("tx_valid%0d", d), 32'(tx_a[d]), 32'h1);
            chk($sformatf("dout%0d", d), 32'(dout_a[d]), 32'(rq[d][0].val));
            last_dout[d] = rq[d][0].val;
            void'(rq[d].pop_front());
          end else begin
            chk($sformatf("tx_idle%0d", d), 32'(tx_a[d]), 32'h0);
            chk($sformatf("dout_hold%0d", d), 32'(dout_a[d]), 32'(last_dout[d]));
          end
          if (eq[d].size() > 0 && eq[d][0] == cyc) begin
            chk($sformatf("addr_err%0d", d), 32'(err_a[d]), 32'h1);
            void'(eq[d].pop_front());
          end else begin
            chk($sformatf("err_idle%0d", d), 32'(err_a[d]), 32'h0);
          end
        end
      end
    end
  end

  // Outputs must clear as soon as reset asserts, without waiting for an edge.
  always @(negedge rst_n) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async_dout%0d", d), 32'(dout_a[d]), 32'h0);
      chk($sformatf("async_tx%0d", d),   32'(tx_a[d]),   32'h0);
      chk($sformatf("async_err%0d", d),  32'(err_a[d]),  32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    din_a[0] = '0; din_a[1] = '0;
    rxv_a[0] = 1'b0; rxv_a[1] = 1'b0;

    // Reset held, with random traffic on both instances.
    repeat (4) begin
      @(negedge clk);
      din_a[0] = 10'($urandom);
      din_a[1] = 10'($urandom);
      rxv_a[0] = 1'b1;
      rxv_a[1] = 1'b1;
    end
    @(negedge clk);
    rxv_a[0] = 1'b0; rxv_a[1] = 1'b0;
    rst_n = 1'b1;
    idle(1);

    // Single access: write 5A at address 2, then read it back.
    send(0, 2'b00, 8'h02);
    send(0, 2'b01, 8'h5A);
    send(0, 2'b10, 8'h02);
    send(0, 2'b11, 8'h00, 8'h5A);
    idle(2);

    // Burst with wrap: 6 -> 7 -> 0.
    send(0, 2'b00, 8'h06);
    send(0, 2'b01, 8'hA1);
    send(0, 2'b01, 8'hA2);
    send(0, 2'b01, 8'hA3);
    send(0, 2'b10, 8'h06);
    send(0, 2'b11, 8'h00, 8'hA1);
    send(0, 2'b11, 8'h00, 8'hA2);
    send(0, 2'b11, 8'h00, 8'hA3);
    idle(2);

    // Out of range on both pointers. A rejected load leaves the pointer alone.
    send(0, 2'b00, 8'h03);
    send(0, 2'b00, 8'h08, 8'h00, 1'b1);
    send(0, 2'b01, 8'h77);
    send(0, 2'b10, 8'h03);
    send(0, 2'b10, 8'hFF, 8'h00, 1'b1);
    send(0, 2'b11, 8'h00, 8'h77);
    // The top legal address (depth-1) is accepted.
    send(0, 2'b00, 8'h07);
    send(0, 2'b01, 8'h99);
    send(0, 2'b10, 8'h07);
    send(0, 2'b11, 8'h00, 8'h99);
    idle(1);

    // Idle gaps: only valid edges read and advance.
    send(0, 2'b00, 8'h04);
    send(0, 2'b01, 8'h44);
    send(0, 2'b01, 8'h45);
    send(0, 2'b10, 8'h04);
    send(0, 2'b11, 8'h00, 8'h44);
    idle(1);
    din_a[0] = 10'h300;
    send(0, 2'b11, 8'h00, 8'h45);
    idle(2);

    // Read-after-write on consecutive cycles.
    send(0, 2'b00, 8'h02);
    send(0, 2'b10, 8'h02);
    send(0, 2'b01, 8'h2B);
    send(0, 2'b11, 8'h00, 8'h2B);
    idle(1);

    // Reset while tx_valid is high, then a read of preserved mem[0].
    send(0, 2'b10, 8'h05);
    send(0, 2'b11, 8'h00, 8'h45);
    @(posedge clk);
    #3;
    rxv_a[0] = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 2'b11, 8'h00, 8'hA3);
    idle(2);

    // With AUTO_INC=0, the pointers hold across data accesses.
    send(1, 2'b00, 8'h02);
    send(1, 2'b01, 8'hC3);
    send(1, 2'b01, 8'hC4);
    send(1, 2'b10, 8'h02);
    send(1, 2'b11, 8'h00, 8'hC4);
    send(1, 2'b11, 8'h00, 8'hC4);
    send(1, 2'b00, 8'h09, 8'h00, 1'b1);
    idle(3);

    chk("rq0_drained", 32'(rq[0].size()), 32'h0);
    chk("rq1_drained", 32'(rq[1].size()), 32'h0);
    chk("eq0_drained", 32'(eq[0].size()), 32'h0);
    chk("eq1_drained", 32'(eq[1].size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
Parametrised successor to the SPI slave's single-port command RAM. It decodes a 2-bit command prefix on each valid input word into set-write-address, write-data, set-read-address and read-data operations. It adds generic depth and data width, independent write and read address pointers with optional auto-increment and wrap for burst transfers, and an out-of-range address error flag. The block sits between the SPI slave deserialiser (rx side) and serialiser (tx side).

Parameters:
MEM_DEPTH, 256, number of words in memory; any value from 2 to 2^ADDR_SIZE.
ADDR_SIZE, 8, pointer width; must satisfy ADDR_SIZE <= DATA_WIDTH and 2^ADDR_SIZE >= MEM_DEPTH.
DATA_WIDTH, 8, memory word width and payload width.
AUTO_INC, 1, 1 = pointer advances after each data access; 0 = pointer holds.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
din  input  DATA_WIDTH+2  bits [DATA_WIDTH+1:DATA_WIDTH] = cmd; bits [DATA_WIDTH-1:0] = payload
rx_valid  input  1  din is valid this cycle
dout  output  DATA_WIDTH  read data
tx_valid  output  1  dout is valid; one-cycle pulse per read
addr_err  output  1  one-cycle pulse when an address command is rejected

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, dout=0, tx_valid=0, addr_err=0. Memory contents are not reset and are preserved across reset.
- A command executes only on a rising edge with rx_valid=1. With rx_valid=0, nothing changes, dout holds, and tx_valid and addr_err are 0.
- cmd 00 (set write address): if payload, zero-extended, is < MEM_DEPTH, then wr_ptr <= payload[ADDR_SIZE-1:0]. Otherwise wr_ptr is unchanged and addr_err=1 for the next cycle.
- cmd 01 (write data): mem[wr_ptr] <= payload. If AUTO_INC=1, wr_ptr <= (wr_ptr==MEM_DEPTH-1) ? 0 : wr_ptr+1.
- cmd 10 (set read address): same range check and error behaviour as cmd 00, applied to rd_ptr.
- cmd 11 (read data): payload is ignored. dout <= mem[rd_ptr] and tx_valid=1, both registered, so they appear in the cycle after the command edge (latency 1). If AUTO_INC=1, rd_ptr advances with the same wrap rule as wr_ptr.
- tx_valid is high only in the cycle after a cmd 11 edge. Back-to-back cmd 11 commands hold tx_valid high continuously, with a new dout each cycle.
- addr_err is high only in the cycle after a rejected cmd 00 or cmd 10.
- Read-after-write to the same address on consecutive cycles returns the newly written data (the write completes at the earlier edge).
- wr_ptr and rd_ptr are fully independent; a write never moves rd_ptr and a read never moves wr_ptr.
- Wrap applies at MEM_DEPTH-1 even when MEM_DEPTH is not a power of two; pointers never hold a value >= MEM_DEPTH.
- Reset asserted mid-burst: outputs clear immediately and pointers return to 0. The first read after release returns mem[0].

Test Plan:
All scenarios use MEM_DEPTH=8, ADDR_SIZE=3, DATA_WIDTH=8, AUTO_INC=1 unless stated.
- Reset: hold rst_n=0 with random din and rx_valid=1 -> dout=00, tx_valid=0, addr_err=0 throughout.
- Single access: din=00_00000010, then 01_01011010, then 10_00000010, then 11_00000000 -> one cycle after the read edge, dout=5A and tx_valid=1 for exactly one cycle.
- Burst with wrap: set wr addr 6, write A1, A2, A3 -> mem[6]=A1, mem[7]=A2, mem[0]=A3. Set rd addr 6, issue three back-to-back reads -> dout sequence A1, A2, A3 with tx_valid high for 3 consecutive cycles.
- Out of range: after wr_ptr=3, send 00_00001000 -> addr_err pulses for one cycle. A following write of 77 lands in mem[3]. Repeat with 10_11111111 -> addr_err pulses and rd_ptr is unchanged.
- Idle gaps: alternate rx_valid 1/0 while a cmd 11 word is on din -> only the rx_valid=1 edges produce tx_valid pulses, and the pointer advances only on those edges.
- Reset mid-burst and AUTO_INC=0: read from address 5, drop rst_n while tx_valid=1 -> tx_valid and dout clear immediately. After release, cmd 11 returns the preserved mem[0]. With AUTO_INC=0, two reads at address 2 both return mem[2].
